// File: rtl/sid_bus_responder.sv
// FPGA-side model of the SID chip bus: oversamples the bus, keeps a shadow of
// the 25 SID registers, queues every accepted write and models the reset pin.
module sid_bus_responder #(
  parameter int unsigned FIFO_AW      = 3,
  parameter int unsigned RESET_CYCLES = 10
) (
  input  logic       C6_CLK_8MHZ,
  input  logic       BTN_0,
  input  logic       SID_CLK,
  input  logic       SID_NOTCS,
  input  logic       SID_NOTRES,
  input  logic [4:0] SID_ADDR,
  input  logic [7:0] SID_DATA,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       ev_valid,
  output logic [4:0] ev_addr,
  output logic [7:0] ev_data,
  input  logic       ev_ready,
  output logic       ev_overflow,
  output logic       chip_reset
);

  localparam int unsigned NUM_REGS = 25;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEPTH    = 1 << FIFO_AW;
  localparam int unsigned PTR_W    = FIFO_AW + 1;
  localparam int unsigned CNT_W    = $clog2(RESET_CYCLES + 1);

  typedef struct packed {
    logic              clk;
    logic              notcs;
    logic              notres;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } event_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    QUAL  = 2'd1,
    CLEAR = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam bus_t BUS_IDLE = '{clk: 1'b0, notcs: 1'b1, notres: 1'b1,
                                addr: '0, data: '0};

  bus_t pins, s1, s2, s3;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              chip_reset_d;

  logic              sid_fall, notres_high, wr_hit;
  logic              pop, push, full, flush;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  event_t            mem [DEPTH];
  event_t            head_nxt;
  logic [DATA_W-1:0] shadow [NUM_REGS];

  assign pins = '{clk: SID_CLK, notcs: SID_NOTCS, notres: SID_NOTRES,
                  addr: SID_ADDR, data: SID_DATA};

  // All bus pins share one synchronizer so they stay mutually aligned; s3 is the edge-detect copy
  always_ff @(posedge C6_CLK_8MHZ) begin
    if (BTN_0) begin
      s1 <= BUS_IDLE;
      s2 <= BUS_IDLE;
      s3 <= BUS_IDLE;
    end else begin
      s1 <= pins;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sid_fall    = s3.clk & ~s2.clk;
  assign notres_high = s2.notres & s3.notres;
  assign wr_hit      = (state_q == RUN) && sid_fall && !s3.notcs &&
                       (s3.addr < ADDR_W'(NUM_REGS));

  // Reset pin state machine: state register
  always_ff @(posedge C6_CLK_8MHZ) begin
    if (BTN_0) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      clr_q      <= '0;
      chip_reset <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_q      <= clr_d;
      chip_reset <= chip_reset_d;
    end
  end

  // Reset pin state machine: next state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_d        = clr_q;
    chip_reset_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!s2.notres) begin
          state_d = QUAL;
          cnt_d   = '0;
        end
      end
      QUAL: begin
        if (cnt_q == CNT_W'(RESET_CYCLES)) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else if (notres_high) begin
          state_d = RUN;
        end else if (sid_fall) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLEAR: begin
        if (clr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = HOLD;
        end else begin
          clr_d = clr_q + ADDR_W'(1);
        end
      end
      HOLD: begin
        if (notres_high) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    chip_reset_d = (state_d == CLEAR) || (state_d == HOLD);
  end

  assign pop        = ev_valid & ev_ready;
  assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push       = wr_hit && (!full || pop);
  assign flush      = (state_q == QUAL) && (state_d == CLEAR);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  assign head_nxt   = mem[rd_ptr_nxt[FIFO_AW-1:0]];

  always_ff @(posedge C6_CLK_8MHZ) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= '{addr: s3.addr, data: s3.data};
    end
  end

  // Head register looks ahead past a pop but not past a push, so new events show one clock later
  always_ff @(posedge C6_CLK_8MHZ) begin
    if (BTN_0) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ev_valid    <= 1'b0;
      ev_addr     <= '0;
      ev_data     <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (wr_hit && full && !pop) begin
        ev_overflow <= 1'b1;
      end
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ev_valid <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        rd_ptr   <= rd_ptr_nxt;
        ev_valid <= (rd_ptr_nxt != wr_ptr);
        if (rd_ptr_nxt != wr_ptr) begin
          ev_addr <= head_nxt.addr;
          ev_data <= head_nxt.data;
        end
      end
    end
  end

  // Shadow registers and registered read port (same-cycle write reads the old value)
  always_ff @(posedge C6_CLK_8MHZ) begin
    if (BTN_0) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      rd_data <= (rd_addr < ADDR_W'(NUM_REGS)) ? shadow[rd_addr] : '0;
      if (wr_hit) begin
        shadow[s3.addr] <= s3.data;
      end else if (state_q == CLEAR) begin
        shadow[clr_q] <= '0;
      end
    end
  end

endmodule
